// File: rtl/mlp_adc_frame_sequencer.sv
// ADC frame sequencer for the combinational printed-MLP classifier.
// Walks the enabled sensor channels over a req/ack handshake and collects the
// samples in a shadow vector. It then loads the vector into the classifier in
// one edge, waits a fixed settle time and registers the argmax class.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, cont           begin a frame (taken in IDLE) / run continuously
//   adc_req, adc_sel      conversion request and channel select to the ADC
//   adc_ack, adc_data     conversion done strobe and sample from the ADC
//   mlp_inp, mlp_out      classifier input vector / combinational argmax result
//   class_out, class_valid registered class and its one-cycle update pulse
//   busy, err             not-IDLE indicator / sticky ack-timeout flag
module mlp_adc_frame_sequencer #(
  parameter int unsigned     N_CH          = 4,
  parameter int unsigned     ADC_BITS      = 4,
  parameter int unsigned     CLS_BITS      = 2,
  parameter logic [N_CH-1:0] CH_MASK       = 4'b1111,
  parameter int unsigned     SETTLE_CYCLES = 2,
  parameter int unsigned     ACK_TIMEOUT   = 15,
  localparam int unsigned    SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cont,
  output logic                     adc_req,
  output logic [SEL_W-1:0]         adc_sel,
  input  logic                     adc_ack,
  input  logic [ADC_BITS-1:0]      adc_data,
  output logic [N_CH*ADC_BITS-1:0] mlp_inp,
  input  logic [CLS_BITS-1:0]      mlp_out,
  output logic [CLS_BITS-1:0]      class_out,
  output logic                     class_valid,
  output logic                     busy,
  output logic                     err
);

  // Counter widths: timeout counts 0..ACK_TIMEOUT-1, settle counts down from SETTLE_CYCLES-1.
  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  logic [1:0]                         r_state, w_state_nxt;
  logic [SEL_W-1:0]                   r_ch, w_ch_nxt;
  logic [N_CH-1:0][ADC_BITS-1:0]      r_shadow, w_shadow_nxt;
  logic [N_CH-1:0][ADC_BITS-1:0]      r_inp, w_inp_nxt;
  logic [CLS_BITS-1:0]                r_class, w_class_nxt;
  logic                               r_valid, w_valid_nxt;
  logic                               r_err, w_err_nxt;
  logic [TMO_W-1:0]                   r_tmo, w_tmo_nxt;
  logic [SET_W-1:0]                   r_set, w_set_nxt;
  logic                               r_req, w_req_nxt;
  logic                               r_busy, w_busy_nxt;

  logic [SEL_W-1:0]                   w_first_ch;
  logic [SEL_W-1:0]                   w_next_ch;
  logic                               w_has_next;

  // Lowest enabled channel, and the lowest enabled channel above the current one.
  always_comb begin
    w_first_ch = '0;
    w_next_ch  = '0;
    w_has_next = 1'b0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (CH_MASK[SEL_W'(i)]) begin
        w_first_ch = SEL_W'(i);
        if (SEL_W'(i) > r_ch) begin
          w_next_ch  = SEL_W'(i);
          w_has_next = 1'b1;
        end
      end
    end
  end

  // Next-state and next-register-value logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_ch_nxt     = r_ch;
    w_shadow_nxt = r_shadow;
    w_inp_nxt    = r_inp;
    w_class_nxt  = r_class;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = r_err;
    w_tmo_nxt    = '0;
    w_set_nxt    = r_set;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_err_nxt = 1'b0;
          if (CH_MASK == '0) begin
            w_inp_nxt   = '0;
            w_set_nxt   = SET_W'(SETTLE_CYCLES - 1);
            w_state_nxt = S_SETTLE;
          end else begin
            w_ch_nxt    = w_first_ch;
            w_state_nxt = S_CONV;
          end
        end
      end
      S_CONV: begin
        if (adc_ack) begin
          w_shadow_nxt[r_ch] = adc_data;
          if (w_has_next) begin
            w_state_nxt = S_GAP;
          end else begin
            // Final sample: the classifier sees the whole new vector in one edge.
            w_inp_nxt   = w_shadow_nxt;
            w_set_nxt   = SET_W'(SETTLE_CYCLES - 1);
            w_state_nxt = S_SETTLE;
          end
        end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_GAP: begin
        w_ch_nxt    = w_next_ch;
        w_state_nxt = S_CONV;
      end
      S_SETTLE: begin
        if (r_set == '0) begin
          w_class_nxt = mlp_out;
          w_valid_nxt = 1'b1;
          if (!cont) begin
            w_state_nxt = S_IDLE;
          end else if (CH_MASK == '0) begin
            w_set_nxt   = SET_W'(SETTLE_CYCLES - 1);
            w_state_nxt = S_SETTLE;
          end else begin
            w_ch_nxt    = w_first_ch;
            w_state_nxt = S_CONV;
          end
        end else begin
          w_set_nxt = r_set - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_req_nxt  = (w_state_nxt == S_CONV);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_shadow <= '0;
      r_inp    <= '0;
      r_class  <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= '0;
      r_set    <= '0;
      r_req    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ch     <= w_ch_nxt;
      r_shadow <= w_shadow_nxt;
      r_inp    <= w_inp_nxt;
      r_class  <= w_class_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
      r_tmo    <= w_tmo_nxt;
      r_set    <= w_set_nxt;
      r_req    <= w_req_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign adc_req     = r_req;
  assign adc_sel     = r_ch;
  assign mlp_inp     = r_inp;
  assign class_out   = r_class;
  assign class_valid = r_valid;
  assign busy        = r_busy;
  assign err         = r_err;

endmodule

// File: tb/tb_mlp_adc_frame_sequencer.sv
// Bench for mlp_adc_frame_sequencer: randomized frames with an ADC responder,
// a scoreboard of expected vector loads and class pulses, and a second
// instance with a sparse channel mask.
module tb_mlp_adc_frame_sequencer;

  localparam int N_CH = 4;
  localparam int SC   = 2;   // settle cycles
  localparam int TO   = 15;  // ack timeout

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, cont, adc_req, adc_ack, class_valid, busy, err;
  logic [1:0]  adc_sel, mlp_out, class_out;
  logic [3:0]  adc_data;
  logic [15:0] mlp_inp;

  logic        b_start, b_cont, b_req, b_ack, b_valid, b_busy, b_err;
  logic [1:0]  b_sel, b_mlp_out, b_class;
  logic [3:0]  b_data;
  logic [15:0] b_inp;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { int cyc; int cls; bit busy; } val_t;
  typedef struct { int cyc; logic [15:0] inp; } inp_t;
  val_t val_q[$];
  inp_t inp_q[$];

  int plan_d [64][4];
  int plan_w [64][4];
  int nf = 0;
  logic [15:0] last_inp = '0;
  int last_cls = 0;

  // Responder / monitor state.
  bit         prev_req = 1'b0;
  logic [1:0] prev_sel = '0;
  int         wcnt = 0;
  int         exp_sel = 0;
  int         rfr = -1;
  logic [15:0] prev_inp = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in classifier: index of the largest 4-bit field, lowest index on ties.
  function automatic logic [1:0] argmax(input logic [15:0] v);
    logic [3:0] best;
    best = v[3:0];
    argmax = 2'd0;
    for (int i = 1; i < 4; i++)
      if (v[i*4 +: 4] > best) begin
        best = v[i*4 +: 4];
        argmax = 2'(i);
      end
  endfunction

  assign mlp_out   = argmax(mlp_inp);
  assign b_mlp_out = argmax(b_inp);

  mlp_adc_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
    .adc_req(adc_req), .adc_sel(adc_sel), .adc_ack(adc_ack), .adc_data(adc_data),
    .mlp_inp(mlp_inp), .mlp_out(mlp_out), .class_out(class_out),
    .class_valid(class_valid), .busy(busy), .err(err)
  );

  mlp_adc_frame_sequencer #(.CH_MASK(4'b1010)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .cont(b_cont),
    .adc_req(b_req), .adc_sel(b_sel), .adc_ack(b_ack), .adc_data(b_data),
    .mlp_inp(b_inp), .mlp_out(b_mlp_out), .class_out(b_class),
    .class_valid(b_valid), .busy(b_busy), .err(b_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_cls(input int k);
    int b = 0;
    for (int i = 1; i < 4; i++) if (plan_d[k][i] > plan_d[k][b]) b = i;
    return b;
  endfunction

  task automatic rand_plan(input int k, input int maxw);
    for (int i = 0; i < 4; i++) begin
      plan_d[k][i] = $urandom_range(0, 15);
      plan_w[k][i] = $urandom_range(0, maxw);
    end
  endtask

  // mode: 1 = vector load expected only, 2 = vector load and class pulse expected.
  task automatic push_exp(input int k, input int t0, input int mode, input bit busy_after,
                          output int vcyc);
    int sum = 0;
    logic [15:0] v = '0;
    inp_t ie;
    val_t ve;
    for (int i = 0; i < 4; i++) begin
      sum += plan_w[k][i];
      v[i*4 +: 4] = 4'(plan_d[k][i]);
    end
    vcyc = t0 + 2 * N_CH + SC + sum;
    if (v != last_inp) begin
      ie.cyc = vcyc - SC;
      ie.inp = v;
      inp_q.push_back(ie);
    end
    last_inp = v;
    if (mode == 2) begin
      ve.cyc = vcyc;
      ve.cls = exp_cls(k);
      ve.busy = busy_after;
      val_q.push_back(ve);
      last_cls = ve.cls;
    end
  endtask

  task automatic do_frame(input int hold, input bit cn, input int mode, output int t0, output int vcyc);
    @(negedge clk);
    start = 1'b1;
    cont = cn;
    t0 = cyc;
    vcyc = 0;
    if (mode != 0) push_exp(nf, t0, mode, cn, vcyc);
    nf++;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, adc_req, 0);
    chk({tag, "_sel"}, adc_sel, 0);
    chk({tag, "_inp"}, mlp_inp, 0);
    chk({tag, "_class"}, class_out, 0);
    chk({tag, "_valid"}, class_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Sparse-mask instance: only channels 1 and 3 may be requested.
  always @(negedge clk) begin
    b_ack  = b_req;
    b_data = (b_sel == 2'd1) ? 4'd7 : (b_sel == 2'd3) ? 4'd4 : 4'd15;
  end

  task automatic run_b();
    int t0;
    int nreq = 0;
    int vseen = 0;
    @(negedge clk);
    b_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (b_req) begin
        chk("b_sel", b_sel, (nreq == 0) ? 1 : 3);
        chk("b_req_cycle", cyc - t0, (nreq == 0) ? 1 : 3);
        nreq++;
      end
      if (b_valid) begin
        vseen++;
        chk("b_valid_cycle", cyc - t0, 6);
        chk("b_class", b_class, 1);
        chk("b_inp", b_inp, 16'h4070);
      end
      @(negedge clk);
    end
    chk("b_req_count", nreq, 2);
    chk("b_valid_count", vseen, 1);
  endtask

  // ADC responder and scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      adc_ack  = 1'b0;
      prev_req = 1'b0;
      wcnt     = 0;
      exp_sel  = 0;
      prev_inp = '0;
    end else begin
      if (adc_req) begin
        if (!prev_req) begin
          chk("sel_order", adc_sel, exp_sel);
          if (exp_sel == 0) rfr++;
        end else begin
          chk("sel_stable", adc_sel, prev_sel);
        end
        if (wcnt >= plan_w[(rfr < 0) ? 0 : rfr][adc_sel]) begin
          adc_ack  = 1'b1;
          adc_data = 4'(plan_d[(rfr < 0) ? 0 : rfr][adc_sel]);
          exp_sel  = (exp_sel + 1) % 4;
          wcnt     = 0;
        end else begin
          adc_ack  = 1'b0;
          adc_data = 4'($urandom);
          wcnt++;
        end
      end else begin
        // Spurious acks with junk data while busy but not requesting.
        wcnt     = 0;
        adc_ack  = busy & 1'($urandom);
        adc_data = 4'($urandom);
        if (!busy) exp_sel = 0;
      end
      prev_req = adc_req;
      prev_sel = adc_sel;

      if (mlp_inp !== prev_inp) begin
        if (inp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL inp_unexpected_change: actual=%0h (cycle %0d)", mlp_inp, cyc);
        end else begin
          inp_t e;
          e = inp_q.pop_front();
          chk("inp_load_cycle", cyc, e.cyc);
          chk("inp_value", mlp_inp, e.inp);
        end
        prev_inp = mlp_inp;
      end

      if (class_valid) begin
        if (val_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL valid_unexpected: class_out=%0d (cycle %0d)", class_out, cyc);
        end else begin
          val_t v;
          v = val_q.pop_front();
          chk("valid_cycle", cyc, v.cyc);
          chk("class_out", class_out, v.cls);
          chk("busy_at_valid", busy, v.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, v1, v2, exp_idle, idle_cyc;
    start = 1'b0;
    cont = 1'b0;
    b_start = 1'b0;
    b_cont = 1'b0;
    adc_ack = 1'b0;
    adc_data = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run_b();

    // Directed frame: data 3,5,9,12 with immediate acks.
    plan_d[nf] = '{3, 5, 9, 12};
    plan_w[nf] = '{0, 0, 0, 0};
    do_frame(1, 1'b0, 2, t0, v1);
    wait_to(v1 + 1);

    // Random frames; the first one holds start high well into the frame.
    for (int r = 0; r < 6; r++) begin
      rand_plan(nf, 3);
      do_frame((r == 0) ? 6 : 1, 1'b0, 2, t0, v1);
      wait_to(v1 + 1);
    end

    // Every ack delayed by three cycles.
    rand_plan(nf, 0);
    plan_w[nf] = '{3, 3, 3, 3};
    do_frame(1, 1'b0, 2, t0, v1);
    wait_to(v1 + 1);

    // Continuous mode across two frames; the second starts on the first pulse.
    rand_plan(nf, 2);
    rand_plan(nf + 1, 2);
    do_frame(1, 1'b1, 2, t0, v1);
    push_exp(nf, v1 - 1, 2, 1'b0, v2);
    nf++;
    wait_to(v1);
    cont = 1'b0;
    wait_to(v2 + 1);

    // Ack withheld on channel 2: abort after the timeout.
    rand_plan(nf, 2);
    plan_w[nf][2] = 200;
    exp_idle = cyc + 1 + 5 * 1 + 2 * 2 + TO + plan_w[nf][0] + plan_w[nf][1];
    do_frame(1, 1'b0, 0, t0, v1);
    exp_idle = t0 + 5 + TO + plan_w[nf-1][0] + plan_w[nf-1][1];
    idle_cyc = -1;
    for (int i = 0; i < 80 && idle_cyc < 0; i++) begin
      if (!busy) idle_cyc = cyc;
      else @(negedge clk);
    end
    chk("tmo_idle_cycle", idle_cyc, exp_idle);
    chk("tmo_err", err, 1);
    chk("tmo_req", adc_req, 0);
    chk("tmo_inp_held", mlp_inp, last_inp);
    chk("tmo_class_held", class_out, last_cls);

    // Next start clears err and runs normally.
    rand_plan(nf, 3);
    do_frame(1, 1'b0, 2, t0, v1);
    chk("err_cleared", err, 0);
    wait_to(v1 + 1);

    // Asynchronous reset in the middle of the second settle cycle.
    rand_plan(nf, 0);
    do_frame(1, 1'b0, 1, t0, v1);
    wait_to(t0 + 9);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    chk("midreset_no_valid", class_valid, 0);
    #2 rst_n = 1'b1;
    last_inp = '0;
    last_cls = 0;

    // Recovery frame after reset.
    rand_plan(nf, 3);
    do_frame(1, 1'b0, 2, t0, v1);
    wait_to(v1 + 1);

    for (int i = 0; i < 50 && (val_q.size() != 0 || inp_q.size() != 0); i++) @(negedge clk);
    chk("valid_queue_drained", val_q.size(), 0);
    chk("inp_queue_drained", inp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
